// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the iterative RV64M multiply/divide sequencer.
package muldiv_pkg;

   localparam int unsigned XLEN = 64;

   localparam logic [2:0] MD_MUL    = 3'd0;
   localparam logic [2:0] MD_MULH   = 3'd1;
   localparam logic [2:0] MD_MULHSU = 3'd2;
   localparam logic [2:0] MD_MULHU  = 3'd3;
   localparam logic [2:0] MD_DIV    = 3'd4;
   localparam logic [2:0] MD_DIVU   = 3'd5;
   localparam logic [2:0] MD_REM    = 3'd6;
   localparam logic [2:0] MD_REMU   = 3'd7;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PREP,
      S_CALC,
      S_FIX,
      S_DONE
   } state_t;

   function automatic logic is_div(input logic [2:0] i_op);
      return i_op[2];
   endfunction

   // Signedness of rs1; rs2 is signed for the same ops except MULHSU.
   function automatic logic is_signed(input logic [2:0] i_op);
      return (i_op == MD_MULH) || (i_op == MD_MULHSU) || (i_op == MD_DIV) || (i_op == MD_REM);
   endfunction

endpackage

// File: rtl/muldiv_iter_step.sv
// One combinational iteration: shift-add multiply step or restoring-divide step.
module muldiv_iter_step
   import muldiv_pkg::*;
(
   input  logic            i_is_div,
   input  logic [XLEN-1:0] i_hi,
   input  logic [XLEN-1:0] i_lo,
   input  logic [XLEN-1:0] i_operand,
   output logic [XLEN-1:0] o_hi,
   output logic [XLEN-1:0] o_lo
);

   logic [XLEN:0] w_sum;
   logic [XLEN:0] w_shl;
   logic [XLEN:0] w_diff;

   always_comb begin
      w_sum  = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_operand} : '0);
      w_shl  = {i_hi, i_lo[XLEN-1]};
      w_diff = w_shl - {1'b0, i_operand};
      if (i_is_div) begin
         // Bit XLEN of the difference is the borrow: clear means the trial subtract fits.
         if (!w_diff[XLEN]) begin
            o_hi = w_diff[XLEN-1:0];
            o_lo = {i_lo[XLEN-2:0], 1'b1};
         end else begin
            o_hi = w_shl[XLEN-1:0];
            o_lo = {i_lo[XLEN-2:0], 1'b0};
         end
      end else begin
         o_hi = w_sum[XLEN:1];
         o_lo = {w_sum[0], i_lo[XLEN-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV64M multiply/divide unit, one bit per cycle with busy/done handshake.
// Define MULDIV_EARLY_OUT_EN to bypass CALC for zero/overflow operands.
module muldiv_sequencer
   import muldiv_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic            WordOp,
   input  logic [XLEN-1:0] operand1,
   input  logic [XLEN-1:0] operand2,
   input  logic            flush,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   state_t          r_state;
   state_t          w_state_next;
   logic [2:0]      r_op;
   logic            r_word;
   logic [XLEN-1:0] r_opa;
   logic [XLEN-1:0] r_opb;
   logic [XLEN-1:0] r_hi;
   logic [XLEN-1:0] r_lo;
   logic [XLEN-1:0] r_operand;
   logic [XLEN-1:0] r_dividend;
   logic [XLEN-1:0] r_result;
   logic [6:0]      r_count;
   logic            r_neg_a;
   logic            r_neg_res;
   logic            r_div_zero;
   logic            r_ovf;

   logic            w_div;
   logic            w_word;
   logic            w_sa;
   logic            w_sb;
   logic [XLEN-1:0] w_a;
   logic [XLEN-1:0] w_b;
   logic            w_neg_a;
   logic            w_neg_b;
   logic [XLEN-1:0] w_abs_a;
   logic [XLEN-1:0] w_abs_b;
   logic            w_div_zero;
   logic            w_ovf;
   logic            w_mul_zero;
   logic            w_early;
   logic [XLEN-1:0] w_step_hi;
   logic [XLEN-1:0] w_step_lo;

   // Operand conditioning, evaluated while in PREP from the captured operands.
   always_comb begin
      w_div  = is_div(r_op);
      w_word = r_word && (w_div || (r_op == MD_MUL));
      w_sa   = is_signed(r_op);
      w_sb   = w_sa && (r_op != MD_MULHSU);
      w_a    = r_opa;
      w_b    = r_opb;
      if (w_word) begin
         w_a = w_sa ? {{32{r_opa[31]}}, r_opa[31:0]} : {32'b0, r_opa[31:0]};
         w_b = w_sb ? {{32{r_opb[31]}}, r_opb[31:0]} : {32'b0, r_opb[31:0]};
      end
      w_neg_a    = w_sa && w_a[XLEN-1];
      w_neg_b    = w_sb && w_b[XLEN-1];
      w_abs_a    = w_neg_a ? -w_a : w_a;
      w_abs_b    = w_neg_b ? -w_b : w_b;
      w_div_zero = w_div && (w_b == '0);
      w_ovf      = w_div && w_sa && (w_b == '1) &&
                   (w_a == (w_word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
      w_mul_zero = !w_div && ((w_a == '0) || (w_b == '0));
`ifdef MULDIV_EARLY_OUT_EN
      w_early = w_div_zero || w_ovf || w_mul_zero;
`else
      w_early = 1'b0;
`endif
   end

   muldiv_iter_step u_step (
      .i_is_div  (w_div),
      .i_hi      (r_hi),
      .i_lo      (r_lo),
      .i_operand (r_operand),
      .o_hi      (w_step_hi),
      .o_lo      (w_step_lo)
   );

   logic [2*XLEN-1:0] w_prod;
   logic [XLEN-1:0]   w_quot;
   logic [XLEN-1:0]   w_rem;
   logic [XLEN-1:0]   w_sel;
   logic [XLEN-1:0]   w_fix;

   always_comb begin
      w_prod = r_neg_res ? -{r_hi, r_lo} : {r_hi, r_lo};
      w_quot = w_word ? {32'b0, r_lo[31:0]} : r_lo;
      if (r_neg_res) begin
         w_quot = -w_quot;
      end
      w_rem = r_neg_a ? -r_hi : r_hi;
      unique case (r_op)
         // Word multiply stops after 32 shifts, leaving the low product word in r_lo[63:32].
         MD_MUL:                        w_sel = w_word ? {32'b0, w_prod[63:32]} : w_prod[63:0];
         MD_MULH, MD_MULHSU, MD_MULHU:  w_sel = w_prod[127:64];
         MD_DIV, MD_DIVU:               w_sel = r_div_zero ? '1 : (r_ovf ? r_dividend : w_quot);
         MD_REM, MD_REMU:               w_sel = r_div_zero ? r_dividend : (r_ovf ? '0 : w_rem);
         default:                       w_sel = '0;
      endcase
      w_fix = w_word ? {{32{w_sel[31]}}, w_sel[31:0]} : w_sel;
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         S_IDLE:  if (start) w_state_next = S_PREP;
         S_PREP:  w_state_next = w_early ? S_FIX : S_CALC;
         S_CALC:  if (r_count == 7'd1) w_state_next = S_FIX;
         S_FIX:   w_state_next = S_DONE;
         S_DONE:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
      if (flush) begin
         w_state_next = S_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_op       <= MD_MUL;
         r_word     <= 1'b0;
         r_opa      <= '0;
         r_opb      <= '0;
         r_hi       <= '0;
         r_lo       <= '0;
         r_operand  <= '0;
         r_dividend <= '0;
         r_result   <= '0;
         r_count    <= '0;
         r_neg_a    <= 1'b0;
         r_neg_res  <= 1'b0;
         r_div_zero <= 1'b0;
         r_ovf      <= 1'b0;
      end else begin
         r_state <= w_state_next;
         case (r_state)
            S_IDLE: begin
               if (start && !flush) begin
                  r_op   <= op;
                  r_word <= WordOp;
                  r_opa  <= operand1;
                  r_opb  <= operand2;
               end
            end
            S_PREP: begin
               r_hi       <= '0;
               r_operand  <= w_div ? w_abs_b : w_abs_a;
               r_dividend <= w_a;
               r_neg_a    <= w_neg_a;
               r_neg_res  <= w_neg_a ^ w_neg_b;
               r_div_zero <= w_div_zero;
               r_ovf      <= w_ovf;
               r_count    <= w_word ? 7'd32 : 7'd64;
               // Dividend enters MSB-first, so word dividends sit in the upper half.
               if (w_div) begin
                  r_lo <= w_word ? {w_abs_a[31:0], 32'b0} : w_abs_a;
               end else begin
                  r_lo <= w_mul_zero ? '0 : w_abs_b;
               end
            end
            S_CALC: begin
               r_hi    <= w_step_hi;
               r_lo    <= w_step_lo;
               r_count <= r_count - 7'd1;
            end
            S_FIX: begin
               if (!flush) begin
                  r_result <= w_fix;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy   = (r_state != S_IDLE);
   assign done   = (r_state == S_DONE);
   assign result = r_result;

endmodule
